fix_session_arbiter: RTL and testbench

- Shares a single FIX tag/value parser among N_SRC independent session byte streams.
- Grants one session at a time, round-robin.
- Holds the grant for a whole FIX message and releases it only after the SOH that terminates the checksum field (tag 10), or on an inactivity timeout.
- Sits directly upstream of the parser. Tags every forwarded byte with its session index.

---
 rtl/fix_session_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_fix_session_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_session_arbiter.sv
// fix_session_arbiter: round-robin share of one FIX parser among N_SRC sessions.
// A grant is held for a whole message, up to the SOH closing tag 10, or until timeout.
module fix_session_arbiter #(
    parameter int N_SRC   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_valid_i,
    input  logic [8*N_SRC-1:0]       src_data_i,
    output logic [N_SRC-1:0]         src_ready_o,
    output logic                     p_valid_o,
    output logic [7:0]               p_data_o,
    input  logic                     p_ready_i,
    output logic [$clog2(N_SRC)-1:0] p_src_o,
    output logic                     msg_start_o,
    output logic                     msg_end_o,
    output logic                     abort_o
);

    localparam int IW = $clog2(N_SRC);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } state_t;

    state_t          st_q, st_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   g_q, g_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      pos_q, pos_d;
    logic            match_q, match_d;
    logic            in_val_q, in_val_d;
    logic            cksum_q, cksum_d;
    logic            started_q, started_d;

    logic            stream;
    logic            sel_valid;
    logic [7:0]      sel_data;
    logic            xfer;
    logic            is_soh;
    logic            is_eq;
    logic            is_one;
    logic            is_zero;
    logic            end_hit;
    logic            tmo_hit;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   lo;
    logic [IW-1:0]   hi;
    logic            hi_ok;

    assign stream    = (st_q == STREAM);
    assign sel_valid = src_valid_i[g_q];
    assign sel_data  = src_data_i[{g_q, 3'b000} +: 8];
    assign xfer      = stream && sel_valid && p_ready_i;
    assign is_soh    = (sel_data == 8'h01);
    assign is_eq     = (sel_data == 8'h3D);
    assign is_one    = (sel_data == 8'h31);
    assign is_zero   = (sel_data == 8'h30);
    assign end_hit   = xfer && is_soh && cksum_q;
    assign tmo_hit   = stream && !sel_valid
                     && (cnt_q == CW'(TIMEOUT - 1));

    // First requester at or above rr_q, else the lowest requester (wrap).
    always_comb begin
        lo    = '0;
        hi    = '0;
        hi_ok = 1'b0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (src_valid_i[j]) begin
                lo = IW'(j);
            end
            if (src_valid_i[j] && j >= int'(rr_q)) begin
                hi    = IW'(j);
                hi_ok = 1'b1;
            end
        end
        pick = hi_ok ? hi : lo;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= IDLE;
            rr_q      <= '0;
            g_q       <= '0;
            cnt_q     <= '0;
            pos_q     <= '0;
            match_q   <= 1'b1;
            in_val_q  <= 1'b0;
            cksum_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            rr_q      <= rr_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            match_q   <= match_d;
            in_val_q  <= in_val_d;
            cksum_q   <= cksum_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        st_d = st_q;
        rr_d = rr_q;
        g_d  = g_q;
        unique case (st_q)
            IDLE: begin
                if (|src_valid_i) begin
                    st_d = STREAM;
                    g_d  = pick;
                    rr_d = (pick == IW'(N_SRC - 1)) ? '0
                                                    : pick + IW'(1);
                end
            end
            STREAM: begin
                if (end_hit || tmo_hit) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (stream && !sel_valid && !tmo_hit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Tag tracker: cksum is set once the tag "10" is followed by '='.
    always_comb begin
        pos_d     = pos_q;
        match_d   = match_q;
        in_val_d  = in_val_q;
        cksum_d   = cksum_q;
        started_d = started_q;
        if (!stream) begin
            pos_d     = '0;
            match_d   = 1'b1;
            in_val_d  = 1'b0;
            cksum_d   = 1'b0;
            started_d = 1'b0;
        end else if (xfer) begin
            started_d = 1'b1;
            unique case (1'b1)
                is_soh: begin
                    pos_d    = '0;
                    match_d  = 1'b1;
                    in_val_d = 1'b0;
                    cksum_d  = 1'b0;
                end
                (!is_soh && in_val_q): begin
                end
                (!is_soh && !in_val_q && is_eq): begin
                    in_val_d = 1'b1;
                    cksum_d  = match_q && (pos_q == 2'd2);
                end
                default: begin
                    unique case (pos_q)
                        2'd0:    match_d = is_one;
                        2'd1:    match_d = match_q && is_zero;
                        default: match_d = 1'b0;
                    endcase
                    if (pos_q != 2'd3) begin
                        pos_d = pos_q + 2'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        src_ready_o = '0;
        p_valid_o   = 1'b0;
        p_data_o    = '0;
        p_src_o     = g_q;
        msg_start_o = 1'b0;
        msg_end_o   = 1'b0;
        abort_o     = 1'b0;
        if (stream) begin
            src_ready_o[g_q] = p_ready_i;
            p_valid_o        = sel_valid;
            p_data_o         = sel_data;
            msg_start_o      = xfer && !started_q;
            msg_end_o        = end_hit;
            abort_o          = tmo_hit && !end_hit;
        end
    end

endmodule

// File: tb/tb_fix_session_arbiter.sv
// tb_fix_session_arbiter: directed FIX streams per session, scoreboard of
// expected parser-side events checked by an independent monitor.
module tb_fix_session_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src_valid_i;
    logic [8*N-1:0] src_data_i;
    logic [N-1:0]   src_ready_o;
    logic           p_valid_o;
    logic [7:0]     p_data_o;
    logic           p_ready_i;
    logic [1:0]     p_src_o;
    logic           msg_start_o;
    logic           msg_end_o;
    logic           abort_o;

    fix_session_arbiter #(.N_SRC(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i),
        .src_ready_o(src_ready_o),
        .p_valid_o(p_valid_o), .p_data_o(p_data_o),
        .p_ready_i(p_ready_i), .p_src_o(p_src_o),
        .msg_start_o(msg_start_o), .msg_end_o(msg_end_o),
        .abort_o(abort_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ab;
        logic [1:0] src;
        logic [7:0] d;
        bit         st;
        bit         en;
        int         gap;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] src_q[N][$];
    bit         hold[N];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         last_end = 0;
    int         last_xfer = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic load(int k, string s, int n_exp, int gap, bit has_end);
        logic [7:0] b;
        ev_t        e;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            if (b == 8'h5E) b = 8'h01;
            src_q[k].push_back(b);
            if (i < n_exp) begin
                e.ab  = 1'b0;
                e.src = 2'(k);
                e.d   = b;
                e.st  = (i == 0);
                e.en  = has_end && (i == s.len() - 1);
                e.gap = (i == 0) ? gap : -1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic exp_abort(int k, int gap);
        ev_t e;
        e.ab  = 1'b1;
        e.src = 2'(k);
        e.d   = 8'h00;
        e.st  = 1'b0;
        e.en  = 1'b0;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    function automatic bit srcs_empty();
        bit r = 1'b1;
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(string name, int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && srcs_empty()) begin
                repeat (12) @(posedge clk);
                #2;
                return;
            end
        end
        n_total++;
        $display("FAIL %s: drain timeout, %0d events left, want 0",
                 name, exp_q.size());
    endtask

    task automatic wait_size(int k, int n, int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (src_q[k].size() == n) return;
        end
        n_total++;
        $display("FAIL wait_size: src %0d size %0d, want %0d",
                 k, src_q[k].size(), n);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        chk("reset_out", {src_ready_o, p_valid_o, p_data_o, p_src_o,
                          msg_start_o, msg_end_o, abort_o}, 32'd0);
        rst = 1'b1;
    endtask

    // Source drivers: pop on an accepted byte, present the next one.
    initial begin
        bit         take[N];
        logic [7:0] tmp;
        src_valid_i = '0;
        src_data_i  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++)
                take[k] = src_valid_i[k] && src_ready_o[k];
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (take[k] && src_q[k].size() > 0) tmp = src_q[k].pop_front();
                src_valid_i[k] = (src_q[k].size() > 0) && !hold[k];
                src_data_i[8*k +: 8] = (src_q[k].size() > 0) ? src_q[k][0]
                                                              : 8'h00;
            end
        end
    end

    // Monitor: every parser-side event must match the scoreboard head.
    initial begin
        ev_t  e;
        logic xf;
        forever begin
            @(negedge clk);
            xf = p_valid_o && p_ready_i;
            if (xf || abort_o || msg_start_o || msg_end_o) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: src=%0d data=%h st=%b en=%b ab=%b, want none",
                             p_src_o, p_data_o, msg_start_o, msg_end_o, abort_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", {18'd0, xf, abort_o, p_src_o,
                                  xf ? p_data_o : 8'h00,
                                  msg_start_o, msg_end_o},
                        {18'd0, !e.ab, e.ab, e.src, e.d, e.st, e.en});
                    if (e.gap >= 0) begin
                        if (e.ab) chk("abort_gap", cyc - last_xfer, e.gap);
                        else      chk("idle_gap", cyc - last_end, e.gap);
                    end
                end
                if (xf) last_xfer = cyc;
                if (msg_end_o) last_end = cyc;
            end
        end
    end

    initial begin
        rst       = 1'b0;
        p_ready_i = 1'b1;
        for (int k = 0; k < N; k++) hold[k] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out", {src_ready_o, p_valid_o, p_data_o, p_src_o,
                          msg_start_o, msg_end_o, abort_o}, 32'd0);
        rst = 1'b1;

        load(0, "8=FIX.4.2^9=5^35=0^10=123^", 26, -1, 1'b1);
        drain("single", 200);
        chk("single_idle", {p_valid_o, src_ready_o, p_src_o}, 32'd0);

        do_reset();
        load(0, "8=A^10=1^", 9, -1, 1'b1);
        load(1, "8=B^10=2^", 9, 2, 1'b1);
        load(2, "8=C^10=3^", 9, 2, 1'b1);
        load(3, "8=D^10=4^", 9, 2, 1'b1);
        drain("round_robin", 200);
        load(0, "8=E^10=5^", 9, -1, 1'b1);
        load(3, "8=F^10=6^", 9, 2, 1'b1);
        drain("rr_wrap", 100);

        load(2, "8=X^110=5^1=5^10=123^", 21, -1, 1'b1);
        wait_size(2, 6, 100);
        p_ready_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        p_ready_i = 1'b1;
        drain("lookalike", 100);

        do_reset();
        load(0, "8=A^9=1^10=0^", 13, -1, 1'b1);
        load(1, "8=C^10=2^", 9, 2, 1'b1);
        load(0, "8=B^9=", 6, 2, 1'b0);
        exp_abort(0, TMO);
        load(1, "8=D^10=3^", 9, -1, 1'b1);
        wait_size(0, 12, 100);
        hold[0] = 1'b1;
        repeat (7) @(posedge clk);
        #2;
        hold[0] = 1'b0;
        drain("timeout", 300);

        load(1, "8=Q^9=5^10=000^", 7, -1, 1'b0);
        wait_size(1, 8, 100);
        src_q[1].delete();
        p_ready_i = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #2;
        chk("mid_reset_out", {src_ready_o, p_valid_o, p_data_o, p_src_o,
                              msg_start_o, msg_end_o, abort_o}, 32'd0);
        rst       = 1'b1;
        p_ready_i = 1'b1;
        @(posedge clk); #2;
        load(1, "8=R^10=4^", 9, -1, 1'b1);
        load(3, "8=S^10=5^", 9, 2, 1'b1);
        drain("restart", 200);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
